mem_arbiter: RTL and testbench

Shares one single-port instruction/data memory between the core's instruction-fetch port and its data load/store port. Each requester uses a request/acknowledge handshake. The arbiter chooses one requester, runs exactly one memory transaction, and returns the result with an acknowledge pulse. It sits between the core and the memory block and replaces separate fetch and load pulses with one arbitrated sequencer.

---
 rtl/riscv_mem_pkg.sv | 17 +
 rtl/rr_arb2.sv | 17 +
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared FSM encoding, owner ids and alignment mask for the memory arbiter.
package riscv_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ERR
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick between fetch and data requests.
module rr_arb2
    import riscv_mem_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic valid,
    output logic owner
);

    always_comb begin
        valid = i_req | d_req;
        owner = (i_req & d_req) ? ~last_grant : (d_req ? OWN_D : OWN_I);
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports,
// one arbitrated transaction at a time with registered acks and strobes.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    state_t state, nxt;
    logic owner, last_grant, we_q;
    logic g_valid, g_owner, g_we, misaligned, done;
    logic [CW-1:0] cnt;

    rr_arb2 u_arb (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .valid      (g_valid),
        .owner      (g_owner)
    );

    always_comb begin
        g_we       = (g_owner == OWN_D) & d_we;
        misaligned = |(d_addr[1:0] & ALIGN_MASK);
        done       = (state == WAIT) && (cnt == LAST);
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (g_valid) nxt = (g_owner == OWN_D && misaligned) ? ERR : ISSUE;
            ISSUE:   nxt = we_q ? RESP : WAIT;
            WAIT:    if (cnt == LAST) nxt = RESP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Transaction latches: captured once at grant, held until the ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_I;
            last_grant <= OWN_I;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (state == IDLE && g_valid) begin
            owner      <= g_owner;
            last_grant <= g_owner;
            we_q       <= g_we;
            mem_addr   <= (g_owner == OWN_D) ? d_addr : i_addr;
            mem_wdata  <= d_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (done && owner == OWN_D) d_rdata <= mem_rdata;
            if (done && owner == OWN_I) i_rdata <= mem_rdata;
        end
    end

    // Outputs are registered from the state being entered so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            busy   <= 1'b0;
            i_ack  <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
        end else begin
            mem_en <= (nxt == ISSUE);
            mem_we <= (nxt == ISSUE) && g_we;
            busy   <= (nxt != IDLE);
            i_ack  <= (nxt == RESP) && (owner == OWN_I);
            d_ack  <= ((nxt == RESP) && (owner == OWN_D)) || (nxt == ERR);
            d_err  <= (nxt == ERR);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and scoreboarded checks of mem_arbiter at MEM_LAT 1 and 3.
module tb_mem_arbiter;

    typedef struct {
        bit          d;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    typedef struct {
        bit          d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        bit          err;
        int          lat;
    } vec_t;

    logic clk, rst;
    logic i_req, i_ack, d_req, d_we, d_ack, d_err, mem_en, mem_we, busy;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic i3_req, i3_ack, d3_ack, d3_err, mem3_en, mem3_we, busy3;
    logic [31:0] i3_addr, i3_rdata, d3_rdata, mem3_addr, mem3_wdata, mem3_rdata;

    bit [31:0] mem [1024];
    bit        wr  [1024];
    logic        pv1, v3a, v3b, v3c;
    logic [31:0] pd1, d3a, d3b, d3c;

    exp_t sb[$];
    vec_t tbl[12];
    int checks, errors, cyc, ack_cnt, en_cnt, en_cyc, ack3_cnt, ack3_cyc, en3_cyc;
    logic en_we;
    logic [31:0] en_addr, en_wdata, ack3_data;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_req(i3_req), .i_addr(i3_addr), .i_ack(i3_ack), .i_rdata(i3_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ack(d3_ack), .d_rdata(d3_rdata), .d_err(d3_err),
        .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
        .mem_rdata(mem3_rdata), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [9:0] a);
        return wr[a] ? mem[a] : ((a == 10'h40) ? 32'hDEADBEEF : (32'hA5000000 | 32'(a)));
    endfunction

    // Memory models: read data is valid only in the exact cycle MEM_LAT after mem_en.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            wr[mem_addr[11:2]]  <= 1'b1;
        end
        pv1 <= mem_en && !mem_we;
        pd1 <= rd(mem_addr[11:2]);
        v3a <= mem3_en;
        d3a <= rd(mem3_addr[11:2]);
        v3b <= v3a;
        d3b <= d3a;
        v3c <= v3b;
        d3c <= d3b;
    end

    assign mem_rdata  = pv1 ? pd1 : 32'hBAD0BAD0;
    assign mem3_rdata = v3c ? d3c : 32'hBAD0BAD0;

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic void push(input bit d, input logic [31:0] data, input bit err, input int cy);
        exp_t e;
        e.d = d;
        e.data = data;
        e.err = err;
        e.cyc = cy;
        sb.push_back(e);
    endfunction

    task automatic mon();
        exp_t e;
        logic [31:0] got;
        if (mem_en) begin
            en_cnt++;
            en_cyc   = cyc;
            en_addr  = mem_addr;
            en_we    = mem_we;
            en_wdata = mem_wdata;
        end
        if (mem3_en) en3_cyc = cyc;
        if (i3_ack) begin
            ack3_cnt++;
            ack3_cyc  = cyc;
            ack3_data = i3_rdata;
        end
        if (i_ack || d_ack) begin
            ack_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got i_ack=%b d_ack=%b at cycle %0d expected no ack", i_ack, d_ack, cyc);
            end else begin
                e = sb.pop_front();
                got = e.d ? d_rdata : i_rdata;
                if (d_ack !== e.d || i_ack !== !e.d || got !== e.data || (e.d && d_err !== e.err) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL ack: got d=%b data=%h err=%b cyc=%0d expected d=%b data=%h err=%b cyc=%0d",
                             d_ack, got, d_err, cyc, e.d, e.data, e.err, e.cyc);
                end
            end
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset(input string p);
        chk1({p, "_i_ack"}, i_ack, 1'b0);
        chk1({p, "_d_ack"}, d_ack, 1'b0);
        chk1({p, "_d_err"}, d_err, 1'b0);
        chk1({p, "_mem_en"}, mem_en, 1'b0);
        chk1({p, "_mem_we"}, mem_we, 1'b0);
        chk1({p, "_busy"}, busy, 1'b0);
        chk32({p, "_mem_addr"}, mem_addr, 32'h0);
        chk32({p, "_mem_wdata"}, mem_wdata, 32'h0);
        chk32({p, "_i_rdata"}, i_rdata, 32'h0);
        chk32({p, "_d_rdata"}, d_rdata, 32'h0);
    endtask

    task automatic run(input vec_t r);
        int c, n, n0;
        c = cyc;
        n = ack_cnt;
        n0 = en_cnt;
        push(r.d, r.exp, r.err, c + r.lat);
        if (r.d) begin
            d_req = 1'b1;
            d_we = r.we;
            d_addr = r.addr;
            d_wdata = r.wdata;
        end else begin
            i_req = 1'b1;
            i_addr = r.addr;
        end
        nxt();
        chk1("busy_high", busy, 1'b1);
        for (int k = 0; k < 20 && ack_cnt == n; k++) nxt();
        i_req = 1'b0;
        d_req = 1'b0;
        chk32("ack_count", 32'(ack_cnt - n), 32'd1);
        chk1("busy_low", busy, 1'b0);
        chk32("mem_en_pulses", 32'(en_cnt - n0), r.err ? 32'd0 : 32'd1);
        if (!r.err) begin
            chk32("mem_en_cycle", 32'(en_cyc), 32'(c + 1));
            chk32("mem_addr", en_addr, r.addr);
            chk1("mem_we", en_we, r.we);
            if (r.we) chk32("mem_wdata", en_wdata, r.wdata);
        end
    endtask

    task automatic both(input logic [31:0] da, input logic [31:0] ia,
                        input logic [31:0] dexp, input logic [31:0] iexp, input int n);
        int c, m;
        c = cyc;
        m = ack_cnt;
        for (int k = 0; k < n; k++)
            push(k % 2 == 0, (k % 2 == 0) ? dexp : iexp, 1'b0, c + 3 + 4 * k);
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = da;
        i_req = 1'b1;
        i_addr = ia;
        for (int k = 0; k < 60 && ack_cnt - m < n; k++) nxt();
        d_req = 1'b0;
        i_req = 1'b0;
        chk32("both_ack_count", 32'(ack_cnt - m), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_reset("reset");
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        int c, n;
        rst = 1'b1;
        {i_req, d_req, d_we, i3_req} = '0;
        {i_addr, d_addr, d_wdata, i3_addr} = '0;
        tbl[0]  = '{1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        tbl[1]  = '{1'b1, 1'b1, 32'h200, 32'h12345678, 32'h00000000, 1'b0, 2};
        tbl[2]  = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h12345678, 1'b0, 3};
        tbl[3]  = '{1'b1, 1'b0, 32'h203, 32'h0,        32'h12345678, 1'b1, 1};
        tbl[4]  = '{1'b0, 1'b0, 32'h200, 32'h0,        32'h12345678, 1'b0, 3};
        tbl[5]  = '{1'b1, 1'b0, 32'h004, 32'h0,        32'hA5000001, 1'b0, 3};
        tbl[6]  = '{1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 32'hA5000001, 1'b0, 2};
        tbl[7]  = '{1'b1, 1'b1, 32'h202, 32'hDEADDEAD, 32'hA5000001, 1'b1, 1};
        tbl[8]  = '{1'b0, 1'b0, 32'h204, 32'h0,        32'hCAFEF00D, 1'b0, 3};
        tbl[9]  = '{1'b0, 1'b0, 32'h102, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        tbl[10] = '{1'b1, 1'b0, 32'h204, 32'h0,        32'hCAFEF00D, 1'b0, 3};
        tbl[11] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h12345678, 1'b0, 3};
        #12;
        chk_reset("init");
        chk1("init_busy3", busy3, 1'b0);
        chk1("init_mem3_en", mem3_en, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i]);

        // Fresh reset so last_grant is fetch: data must win the first tie.
        do_reset();
        both(32'h204, 32'h100, 32'hCAFEF00D, 32'hDEADBEEF, 4);

        // Abort a data load in WAIT, then a tie must again go to data first.
        c = cyc;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h004;
        nxt();
        nxt();
        chk1("pre_abort_busy", busy, 1'b1);
        rst = 1'b1;
        d_req = 1'b0;
        #1;
        chk_reset("abort");
        nxt();
        nxt();
        rst = 1'b0;
        chk32("abort_cycle", 32'(cyc), 32'(c + 4));
        both(32'h200, 32'h204, 32'h12345678, 32'hCAFEF00D, 2);

        // MEM_LAT=3 fetch on the second instance.
        c = cyc;
        n = ack3_cnt;
        i3_req = 1'b1;
        i3_addr = 32'h100;
        for (int k = 0; k < 30 && ack3_cnt == n; k++) nxt();
        i3_req = 1'b0;
        chk32("lat3_ack_count", 32'(ack3_cnt - n), 32'd1);
        chk32("lat3_ack_cycle", 32'(ack3_cyc), 32'(c + 5));
        chk32("lat3_mem_en_cycle", 32'(en3_cyc), 32'(c + 1));
        chk32("lat3_rdata", ack3_data, 32'hDEADBEEF);
        chk1("lat3_no_dack", d3_ack | d3_err | mem3_we, 1'b0);
        chk32("lat3_d_rdata", d3_rdata, 32'h0);
        chk32("lat3_mem_wdata", mem3_wdata, 32'h0);

        nxt();
        nxt();
        chk32("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
